// File: rtl/bitbakery_tx_frame_sequencer_if.sv
// Handshake between the frame sequencer and the byte-level 8E1 transmitter,
// plus the sequencer's frame status outputs.
interface bitbakery_tx_frame_sequencer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [7:0] byte_index;
  logic       busy;
  logic       frame_done;

  modport master (
    output tx_start, tx_data, byte_index, busy, frame_done,
    input  tx_done
  );

  modport slave (
    input  tx_start, tx_data, byte_index, busy, frame_done,
    output tx_done
  );
endinterface

// File: rtl/bitbakery_tx_frame_sequencer.sv
// Snapshots game state and serialises it as a 133-byte frame over a start/done
// byte handshake. Define BITBAKERY_TX_CHECKSUM_EN to send an XOR checksum as the trailer.
module bitbakery_tx_frame_sequencer #(
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
  parameter logic [7:0]  TRAILER_BYTE = 8'h5A,
  parameter int unsigned GAP_CYCLES   = 1000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [7:0]                            D0,
  input  logic [7:0]                            D1,
  input  logic [7:0]                            D2,
  input  logic [511:0]                          map_obstacles,
  input  logic [511:0]                          map_objectives,
  bitbakery_tx_frame_sequencer_if.master        tx
);

  localparam int unsigned      GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       LAST_IDX = 8'd132;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;

  state_t           state;
  logic             advance;
  logic [GAP_W-1:0] gap_cnt;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic [7:0]       byte_idx;
  logic             busy_q;
  logic             frame_done_q;
  logic [7:0]       snap_d0, snap_d1, snap_d2;
  logic [511:0]     snap_obs, snap_obj;
  logic [7:0]       frame_byte;
  logic [7:0]       trailer;
  logic [5:0]       obs_k, obj_k;

`ifdef BITBAKERY_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign trailer = csum;
`else
  assign trailer = TRAILER_BYTE;
`endif

  assign obs_k = 6'(byte_idx - 8'd4);
  assign obj_k = 6'(byte_idx - 8'd68);

  // NOTE: every path assigns frame_byte, so this stays pure combinational (no latch).
  always_comb begin
    if (byte_idx == 8'd0)       frame_byte = HEADER_BYTE;
    else if (byte_idx == 8'd1)  frame_byte = snap_d0;
    else if (byte_idx == 8'd2)  frame_byte = snap_d1;
    else if (byte_idx == 8'd3)  frame_byte = snap_d2;
    else if (byte_idx < 8'd68)  frame_byte = snap_obs[{obs_k, 3'b000} +: 8];
    else if (byte_idx < 8'd132) frame_byte = snap_obj[{obj_k, 3'b000} +: 8];
    else                        frame_byte = trailer;
  end

  // advance marks the cycle that registers the incremented index; SEND follows it,
  // so tx_start lands exactly two cycles after the accepted tx_done.
  // NOTE: all state here uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      advance      <= 1'b0;
      gap_cnt      <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      byte_idx     <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      // NOTE: the snapshot is a plain register bank, not a RAM, so it can be reset.
      snap_d0      <= 8'h00;
      snap_d1      <= 8'h00;
      snap_d2      <= 8'h00;
      snap_obs     <= '0;
      snap_obj     <= '0;
`ifdef BITBAKERY_TX_CHECKSUM_EN
      csum         <= 8'h00;
`endif
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          snap_d0    <= D0;
          snap_d1    <= D1;
          snap_d2    <= D2;
          snap_obs   <= map_obstacles;
          snap_obj   <= map_objectives;
          byte_idx   <= 8'd0;
          tx_data_q  <= HEADER_BYTE;
          tx_start_q <= 1'b1;
          state      <= SEND;
`ifdef BITBAKERY_TX_CHECKSUM_EN
          csum       <= 8'h00;
`endif
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (advance) begin
            advance    <= 1'b0;
            tx_data_q  <= frame_byte;
            tx_start_q <= 1'b1;
            state      <= SEND;
`ifdef BITBAKERY_TX_CHECKSUM_EN
            if (byte_idx != LAST_IDX) csum <= csum ^ frame_byte;
`endif
          end else if (tx.tx_done) begin
            if (byte_idx != LAST_IDX) begin
              byte_idx <= byte_idx + 8'd1;
              advance  <= 1'b1;
            end else begin
              frame_done_q <= 1'b1;
              if (GAP_CYCLES > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
                busy_q  <= 1'b0;
              end else if (enable) begin
                state <= LOAD;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (enable) begin
              state  <= LOAD;
              busy_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx.tx_start   = tx_start_q;
  assign tx.tx_data    = tx_data_q;
  assign tx.byte_index = byte_idx;
  assign tx.busy       = busy_q;
  assign tx.frame_done = frame_done_q;

endmodule

// File: tb/tb_bitbakery_tx_frame_sequencer.sv
// Self-checking bench: timestamp-based frame model compared every cycle, plus
// hand-computed literal checks of the transmitted bytes and handshake timing.
`timescale 1ns/1ps
module tb_bitbakery_tx_frame_sequencer;

  localparam int GAP  = 10;
  localparam int LAST = 132;
`ifdef BITBAKERY_TX_CHECKSUM_EN
  localparam bit         CSUM_ON   = 1'b1;
  localparam logic [7:0] TRAIL_LIT = 8'hFF;
`else
  localparam bit         CSUM_ON   = 1'b0;
  localparam logic [7:0] TRAIL_LIT = 8'h5A;
`endif

  logic         clock = 1'b0;
  logic         reset, enable, toggle, flip;
  logic [7:0]   d0, d1, d2, d0_in;
  logic [511:0] obs, obj, obs_in, obj_in;
  logic         xmit_done, spur_done;
  int           cyc = 0;
  int           n_pass = 0, n_total = 0;
  int           n_starts = 0, n_fdone = 0;
  logic [7:0]   sent[$];

  bitbakery_tx_frame_sequencer_if bus ();
  assign bus.tx_done = xmit_done | spur_done;
  assign d0_in  = d0 ^ {8{flip}};
  assign obs_in = obs ^ {512{flip}};
  assign obj_in = obj ^ {512{flip}};

  bitbakery_tx_frame_sequencer #(
    .HEADER_BYTE(8'hA5), .TRAILER_BYTE(8'h5A), .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .D0(d0_in), .D1(d1), .D2(d2),
    .map_obstacles(obs_in), .map_objectives(obj_in),
    .tx(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hand-written expected bytes for the directed data pattern.
  function automatic logic [7:0] lit_byte(input int i);
    case (i)
      0:       return 8'hA5;
      1:       return 8'h11;
      2:       return 8'h22;
      3:       return 8'h33;
      4:       return 8'hF0;
      131:     return 8'h0F;
      132:     return TRAIL_LIT;
      default: return 8'h00;
    endcase
  endfunction

  // Byte transmitter: tx_done five cycles after each tx_start; forgets work when idle.
  initial begin : xmit
    int cnt;
    cnt = 0;
    xmit_done = 1'b0;
    forever begin
      step();
      xmit_done = 1'b0;
      if (!bus.busy) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) xmit_done = 1'b1;
      end
      if (bus.tx_start) begin
        cnt = 5;
        sent.push_back(bus.tx_data);
        n_starts++;
      end
      if (bus.frame_done) n_fdone++;
    end
  end

  // Input scrambler for the snapshot-integrity test.
  initial begin : scrambler
    flip = 1'b0;
    forever begin
      @(negedge clock);
      flip = toggle ? ~flip : 1'b0;
    end
  end

  // Frame model: expected outputs are derived from event timestamps.
  logic [7:0] m_frame [0:132];
  logic       e_start, e_busy, e_fdone;
  logic [7:0] e_data, e_idx;
  int         load_at, start_at, gap_end, m_idx;
  bit         idle, waiting;

  task automatic capture_frame();
    logic [7:0] x;
    m_frame[0] = 8'hA5;
    m_frame[1] = d0_in;
    m_frame[2] = d1;
    m_frame[3] = d2;
    for (int k = 0; k < 64; k++) begin
      m_frame[4 + k]  = obs_in[8*k +: 8];
      m_frame[68 + k] = obj_in[8*k +: 8];
    end
    x = 8'h00;
    for (int i = 1; i <= 131; i++) x ^= m_frame[i];
    m_frame[132] = CSUM_ON ? x : 8'h5A;
  endtask

  initial begin : model
    bit n_start, n_fdone;
    e_start = 0; e_busy = 0; e_fdone = 0; e_data = 0; e_idx = 0;
    load_at = -1; start_at = -1; gap_end = -1; m_idx = 0;
    idle = 1; waiting = 0;
    forever begin
      @(posedge clock);
      #2;
      check("cycle_outputs",
            {13'b0, bus.tx_start, bus.tx_data, bus.byte_index, bus.busy, bus.frame_done},
            {13'b0, e_start, e_data, e_idx, e_busy, e_fdone});
      n_start = 0;
      n_fdone = 0;
      if (reset) begin
        e_data = 0; e_idx = 0; e_busy = 0; m_idx = 0;
        load_at = -1; start_at = -1; gap_end = -1;
        idle = 1; waiting = 0;
      end else begin
        if (idle && enable) begin
          idle = 0;
          load_at = cyc + 1;
          e_busy = 1;
        end
        if (cyc == load_at) begin
          capture_frame();
          m_idx = 0;
          e_idx = 0;
          start_at = cyc + 1;
        end
        if (waiting && bus.tx_done) begin
          waiting = 0;
          if (m_idx < LAST) begin
            m_idx++;
            e_idx = 8'(m_idx);
            start_at = cyc + 2;
          end else begin
            n_fdone = 1;
            gap_end = cyc + GAP;
            e_busy = 0;
          end
        end
        if (cyc == start_at) waiting = 1;
        if (cyc == gap_end) begin
          if (enable) begin
            load_at = cyc + 1;
            e_busy = 1;
          end else begin
            idle = 1;
          end
        end
        if (cyc + 1 == start_at) begin
          n_start = 1;
          e_data = m_frame[m_idx];
        end
      end
      e_start = n_start;
      e_fdone = n_fdone;
    end
  end

  task automatic wait_frame_done(input string name, input int budget);
    for (int i = 0; i < budget && !bus.frame_done; i++) step();
    check(name, bus.frame_done, 1'b1);
  endtask

  task automatic check_frame(input string name, input int base);
    int bad;
    bad = 0;
    for (int i = 0; i <= LAST; i++)
      if (base + i >= sent.size() || sent[base + i] !== lit_byte(i)) bad++;
    check(name, bad, 0);
  endtask

  initial begin : stimulus
    int t0, t_fd;
    reset = 1; enable = 0; toggle = 0; spur_done = 0;
    d0 = 0; d1 = 0; d2 = 0; obs = '0; obj = '0;

    // Reset and idle, with one stray tx_done while idle.
    repeat (3) step();
    check("reset_tx_start", bus.tx_start, 1'b0);
    check("reset_tx_data", bus.tx_data, 8'h00);
    check("reset_byte_index", bus.byte_index, 8'd0);
    check("reset_busy", bus.busy, 1'b0);
    reset = 0;
    repeat (20) step();
    spur_done = 1; step(); spur_done = 0;
    repeat (29) step();
    check("idle_no_start", n_starts, 0);
    check("idle_index_after_spur", bus.byte_index, 8'd0);

    // Frame 1: directed pattern.
    d0 = 8'h11; d1 = 8'h22; d2 = 8'h33;
    obs[7:0] = 8'hF0;
    obj[511:504] = 8'h0F;
    enable = 1;
    t0 = cyc;
    for (int i = 0; i < 10 && !bus.tx_start; i++) step();
    check("first_start_latency", cyc - t0, 2);
    check("first_header", bus.tx_data, 8'hA5);
    wait_frame_done("frame1_done_seen", 2000);
    check("frame1_start_count", n_starts, 133);
    check("frame1_done_count", n_fdone, 1);
    check("frame1_idx4", sent[4], 8'hF0);
    check("frame1_idx131", sent[131], 8'h0F);
    check("frame1_trailer", sent[132], TRAIL_LIT);
    check_frame("frame1_bytes_bad", 0);

    // Gap with enable held, stray tx_done inside the gap.
    t_fd = cyc;
    for (int i = 0; i < 30 && !bus.busy; i++) begin
      spur_done = (i == 3);
      step();
    end
    spur_done = 0;
    check("gap_length", cyc - t_fd, GAP);
    check("gap_no_start", n_starts, 133);

    // Frame 2: scramble inputs after LOAD; tx_done coincident with the header start.
    step();
    toggle = 1;
    check("frame2_header_start", bus.tx_start, 1'b1);
    check("frame2_header_data", bus.tx_data, 8'hA5);
    spur_done = 1; step(); spur_done = 0;
    check("coincident_done_index", bus.byte_index, 8'd0);
    for (int i = 0; i < 1000 && bus.byte_index != 8'd50; i++) step();
    check("reached_byte50", bus.byte_index, 8'd50);
    enable = 0;
    wait_frame_done("frame2_done_seen", 2000);
    toggle = 0;
    check("frame2_start_count", n_starts, 266);
    check_frame("frame2_bytes_bad", 133);
    repeat (100) step();
    check("after_drop_no_start", n_starts, 266);
    check("after_drop_busy", bus.busy, 1'b0);
    check("after_drop_index", bus.byte_index, 8'd132);

    // Reset in the middle of a frame, then restart from the header.
    enable = 1;
    for (int i = 0; i < 2000 && !(bus.byte_index == 8'd70 && !bus.tx_start); i++) step();
    check("reached_byte70", bus.byte_index, 8'd70);
    reset = 1; step(); reset = 0;
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_index", bus.byte_index, 8'd0);
    check("midreset_tx_data", bus.tx_data, 8'h00);
    t0 = cyc;
    for (int i = 0; i < 10 && !bus.tx_start; i++) step();
    check("restart_latency", cyc - t0, 2);
    check("restart_header", bus.tx_data, 8'hA5);
    check("restart_index", bus.byte_index, 8'd0);
    enable = 0;
    wait_frame_done("frame3_done_seen", 2000);
    repeat (30) step();
    check("total_frame_done", n_fdone, 3);
    check("final_busy", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
